// File: rtl/ladder_result_serializer_if.sv
// Output word bus of the ladder result serializer: 56-bit beats, valid/ready, last marker.
interface ladder_result_serializer_if #(
    parameter int WORD_W = 56
);
    logic [WORD_W-1:0] bus_output;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_last;

    // The serializer drives data/valid/last and receives ready.
    modport master (
        output bus_output,
        output bus_valid,
        output bus_last,
        input  bus_ready
    );

    // The sink receives data/valid/last and drives ready.
    modport slave (
        input  bus_output,
        input  bus_valid,
        input  bus_last,
        output bus_ready
    );
endinterface

// File: rtl/ladder_result_serializer.sv
// Latches a finished ladder result (X, optionally Z) and streams it out
// least-significant word first as WORD_W-bit beats. Every output is a flop;
// the next-beat values are precomputed from the next state, so ready and load
// never reach an output combinationally.
module ladder_result_serializer #(
    parameter int WORD_W = 56,
    parameter int WORDS  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [WORD_W*WORDS-1:0]   x_in,
    input  logic [WORD_W*WORDS-1:0]   z_in,
    input  logic                      send_z,
    ladder_result_serializer_if.master bus,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
);
    localparam int OP_W  = WORD_W * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_X = 2'd1,
        SEND_Z = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   x_hold_q, x_hold_d;
    logic [OP_W-1:0]   z_hold_q, z_hold_d;
    logic              send_z_q, send_z_d;
    logic [WORD_W-1:0] bus_output_q, bus_output_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_last_q, bus_last_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              overrun_q, overrun_d;

    logic              hs;
    logic              final_hs;
    logic              accept;

    // Next-state, hold capture, and next registered output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_hold_d     = x_hold_q;
        z_hold_d     = z_hold_q;
        send_z_d     = send_z_q;

        hs       = bus_valid_q && bus.bus_ready;
        final_hs = hs && (cnt_q == LAST_K) &&
                   ((state_q == SEND_Z) || ((state_q == SEND_X) && !send_z_q));
        // A new result may enter when idle, or exactly as the last beat leaves.
        accept   = load && ((state_q == IDLE) || final_hs);

        if (accept) begin
            x_hold_d = x_in;
            z_hold_d = z_in;
            send_z_d = send_z;
            cnt_d    = '0;
            state_d  = SEND_X;
        end else if (hs) begin
            case (state_q)
                SEND_X: begin
                    if (cnt_q != LAST_K) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (send_z_q) begin
                        cnt_d   = '0;
                        state_d = SEND_Z;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                SEND_Z: begin
                    if (cnt_q != LAST_K) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs reflect the beat that will be presented after this edge.
        bus_output_d = '0;
        case (state_d)
            SEND_X:  bus_output_d = x_hold_d[WORD_W*int'(cnt_d) +: WORD_W];
            SEND_Z:  bus_output_d = z_hold_d[WORD_W*int'(cnt_d) +: WORD_W];
            default: bus_output_d = '0;
        endcase
        bus_valid_d  = (state_d != IDLE);
        bus_last_d   = (cnt_d == LAST_K) &&
                       ((state_d == SEND_Z) || ((state_d == SEND_X) && !send_z_d));
        busy_d       = (state_d != IDLE);
        frame_done_d = final_hs;
        overrun_d    = load && !accept;
    end

    // All state and outputs, cleared asynchronously (partial frame discarded).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            x_hold_q     <= '0;
            z_hold_q     <= '0;
            send_z_q     <= 1'b0;
            bus_output_q <= '0;
            bus_valid_q  <= 1'b0;
            bus_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_hold_q     <= x_hold_d;
            z_hold_q     <= z_hold_d;
            send_z_q     <= send_z_d;
            bus_output_q <= bus_output_d;
            bus_valid_q  <= bus_valid_d;
            bus_last_q   <= bus_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.bus_output = bus_output_q;
    assign bus.bus_valid  = bus_valid_q;
    assign bus.bus_last   = bus_last_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_ladder_result_serializer.sv
// Scoreboard bench for ladder_result_serializer: expected beats are queued when
// a frame is loaded and popped by a monitor on every observed handshake.
module tb_ladder_result_serializer;
    localparam int WORD_W = 56;
    localparam int WORDS  = 8;
    localparam int OP_W   = WORD_W * WORDS;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            load = 1'b0;
    logic [OP_W-1:0] x_in = '0;
    logic [OP_W-1:0] z_in = '0;
    logic            send_z = 1'b0;
    logic            busy, frame_done, overrun;

    ladder_result_serializer_if #(.WORD_W(WORD_W)) bus ();

    ladder_result_serializer #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .x_in       (x_in),
        .z_in       (z_in),
        .send_z     (send_z),
        .bus        (bus.master),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [WORD_W:0] exp_q[$];   // {last, data}

    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic [WORD_W-1:0] prev_data = '0;
    logic            prev_last = 1'b0;

    // Monitor: stall stability and scoreboard comparison at the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                checks++;
                if (bus.bus_valid !== 1'b1 || bus.bus_output !== prev_data || bus.bus_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             bus.bus_valid, bus.bus_output, bus.bus_last, prev_data, prev_last);
                end
            end
            if (bus.bus_valid === 1'b1 && bus.bus_ready === 1'b1) begin
                logic [WORD_W:0] e;
                hs_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got d=%h l=%b want no beat", bus.bus_output, bus.bus_last);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.bus_output !== e[WORD_W-1:0] || bus.bus_last !== e[WORD_W]) begin
                        errors++;
                        $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                                 bus.bus_output, bus.bus_last, e[WORD_W-1:0], e[WORD_W]);
                    end
                end
            end
            prev_valid = bus.bus_valid;
            prev_ready = bus.bus_ready;
            prev_data  = bus.bus_output;
            prev_last  = bus.bus_last;
        end
    end

    function automatic logic [OP_W-1:0] mk_op(input logic [47:0] hi, input bit rep);
        logic [OP_W-1:0] v;
        logic [7:0] b;
        v = '0;
        for (int k = 0; k < WORDS; k++) begin
            b = 8'(k);
            v[WORD_W*k +: WORD_W] = rep ? {7{b}} : {hi, b};
        end
        return v;
    endfunction

    task automatic push_frame(input logic [OP_W-1:0] x, input logic [OP_W-1:0] z, input logic sz);
        for (int k = 0; k < WORDS; k++)
            exp_q.push_back({(!sz && k == WORDS-1), x[WORD_W*k +: WORD_W]});
        if (sz)
            for (int k = 0; k < WORDS; k++)
                exp_q.push_back({(k == WORDS-1), z[WORD_W*k +: WORD_W]});
    endtask

    // Drive a one-cycle load; returns after the sampling edge (+1).
    task automatic pulse_load(input logic [OP_W-1:0] x, input logic [OP_W-1:0] z, input logic sz);
        x_in = x; z_in = z; send_z = sz; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        x_in = ~x; z_in = ~z; send_z = ~sz;   // later input changes must not matter
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: got pending=%0d busy=%b want pending=0 busy=0", name, exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (bus.bus_output !== '0 || bus.bus_valid !== 1'b0 || bus.bus_last !== 1'b0 ||
            busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: got d=%h v=%b l=%b busy=%b fd=%b ov=%b want all 0", name,
                     bus.bus_output, bus.bus_valid, bus.bus_last, busy, frame_done, overrun);
        end
    endtask

    task automatic test_reset();
        bus.bus_ready = 1'b1;
        reset = 1'b0;
        #1;
        check_idle_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_x_only();
        logic [OP_W-1:0] x;
        x = mk_op(48'h0, 1'b1);
        bus.bus_ready = 1'b1;
        push_frame(x, '0, 1'b0);
        pulse_load(x, '0, 1'b0);
        checks++;
        if (bus.bus_valid !== 1'b1 || bus.bus_output !== x[WORD_W-1:0]) begin
            errors++;
            $display("FAIL x_first_beat: got v=%b d=%h want v=1 d=%h", bus.bus_valid, bus.bus_output, x[WORD_W-1:0]);
        end
        repeat (WORDS) @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || bus.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL x_frame_done: got fd=%b busy=%b v=%b want fd=1 busy=0 v=0", frame_done, busy, bus.bus_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0 || bus.bus_output !== '0) begin
            errors++;
            $display("FAIL x_done_pulse: got fd=%b d=%h want fd=0 d=0", frame_done, bus.bus_output);
        end
        drain("x_only");
    endtask

    task automatic test_xz();
        logic [OP_W-1:0] x, z;
        int start;
        x = mk_op(48'hAAAAAAAAAAAA, 1'b0);
        z = mk_op(48'hBBBBBBBBBBBB, 1'b0);
        bus.bus_ready = 1'b1;
        push_frame(x, z, 1'b1);
        start = hs_count;
        pulse_load(x, z, 1'b1);
        repeat (2*WORDS - 1) @(posedge clk);
        #1;
        checks++;
        if (bus.bus_valid !== 1'b1 || bus.bus_last !== 1'b1 || bus.bus_output !== z[WORD_W*(WORDS-1) +: WORD_W]) begin
            errors++;
            $display("FAIL xz_last_beat: got v=%b l=%b d=%h want v=1 l=1 d=%h",
                     bus.bus_valid, bus.bus_last, bus.bus_output, z[WORD_W*(WORDS-1) +: WORD_W]);
        end
        @(posedge clk); #1;
        checks++;
        if (hs_count - start != 2*WORDS || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL xz_throughput: got beats=%0d fd=%b want beats=%0d fd=1", hs_count - start, frame_done, 2*WORDS);
        end
        drain("xz");
    endtask

    task automatic test_backpressure();
        logic [OP_W-1:0] x;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int start, n;
        x = mk_op(48'h123456789ABC, 1'b0);
        bus.bus_ready = 1'b1;
        push_frame(x, '0, 1'b0);
        start = hs_count;
        pulse_load(x, '0, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            bus.bus_ready = pat[n % 4];
            @(posedge clk); #1;
            n++;
        end
        bus.bus_ready = 1'b1;
        checks++;
        if (hs_count - start != WORDS || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got beats=%0d busy=%b want beats=%0d busy=0", hs_count - start, busy, WORDS);
        end
        drain("backpressure");
    endtask

    task automatic test_overrun();
        logic [OP_W-1:0] x, x2;
        x  = mk_op(48'hC0FFEE000000, 1'b0);
        x2 = mk_op(48'hDEAD00000000, 1'b0);
        bus.bus_ready = 1'b1;
        push_frame(x, '0, 1'b0);
        pulse_load(x, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        pulse_load(x2, x2, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b want 1", overrun);
        end
        @(posedge clk); #1;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_once: got %b want 0", overrun);
        end
        drain("overrun");
    endtask

    task automatic test_back_to_back();
        logic [OP_W-1:0] a, b;
        int start;
        a = mk_op(48'h111111111111, 1'b0);
        b = mk_op(48'h222222222222, 1'b0);
        bus.bus_ready = 1'b1;
        push_frame(a, '0, 1'b0);
        push_frame(b, '0, 1'b0);
        start = hs_count;
        pulse_load(a, '0, 1'b0);
        repeat (WORDS - 1) @(posedge clk);
        #1;
        pulse_load(b, '0, 1'b0);
        checks++;
        if (frame_done !== 1'b1 || bus.bus_valid !== 1'b1 || bus.bus_output !== b[WORD_W-1:0] || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: got fd=%b v=%b d=%h ov=%b want fd=1 v=1 d=%h ov=0",
                     frame_done, bus.bus_valid, bus.bus_output, overrun, b[WORD_W-1:0]);
        end
        drain("back_to_back");
        checks++;
        if (hs_count - start != 2*WORDS) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", hs_count - start, 2*WORDS);
        end
    endtask

    task automatic test_reset_midframe();
        logic [OP_W-1:0] x, y;
        x = mk_op(48'h5A5A5A5A5A5A, 1'b0);
        y = mk_op(48'h3C3C3C3C3C3C, 1'b0);
        bus.bus_ready = 1'b1;
        push_frame(x, x, 1'b1);
        pulse_load(x, x, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        bus.bus_ready = 1'b0;
        checks++;
        if (bus.bus_output !== x[WORD_W*4 +: WORD_W]) begin
            errors++;
            $display("FAIL rst_mid_beat4: got %h want %h", bus.bus_output, x[WORD_W*4 +: WORD_W]);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_idle_outputs("rst_mid_async");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.bus_ready = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("rst_mid_idle");
        push_frame(y, '0, 1'b0);
        pulse_load(y, '0, 1'b0);
        checks++;
        if (bus.bus_output !== y[WORD_W-1:0] || bus.bus_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_restart: got v=%b d=%h want v=1 d=%h", bus.bus_valid, bus.bus_output, y[WORD_W-1:0]);
        end
        drain("reset_midframe");
    endtask

    initial begin
        bus.bus_ready = 1'b1;
        test_reset();
        test_x_only();
        test_xz();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
